count_avg_bcd: RTL

Downstream consumer of the 16-bit pulse-count decimator. It accumulates successive window counts, produces a truncated average over 2^AVG_LOG2 windows, and converts that average to 5-digit packed BCD with a sequential shift-add-3 (double-dabble) engine. The result goes to the display/readout stage through a valid/ready handshake.

---
 rtl/count_avg_bcd.sv | 130 +++++++++++++
 1 files changed

// File: rtl/count_avg_bcd.sv
// count_avg_bcd: averages 2^AVG_LOG2 window counts and converts
// the truncated average to 5-digit packed BCD with a serial double-dabble.
module count_avg_bcd #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [15:0] DIN,
  input  logic        STB,
  output logic [19:0] BCD_OUT,
  output logic        VALID,
  input  logic        READY,
  output logic        BUSY,
  output logic        DROP
);

  localparam int AW = 16 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NS = 1 << AVG_LOG2;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [35:0]   sr_q, sr_d, sr_adj;
  logic [3:0]    bit_q, bit_d;
  logic [19:0]   bcd_q, bcd_d;
  logic          drop_q, drop_d;

  logic [AW-1:0] sum;
  logic [AW-1:0] shr;
  logic [15:0]   avg;
  logic          complete;
  logic          xfer;
  logic          accept;

  assign sum      = acc_q + AW'(DIN);
  assign shr      = sum >> AVG_LOG2;
  assign avg      = shr[15:0];
  assign complete = STB && (cnt_q == LAST);
  assign xfer     = (state_q == DONE) && READY;
  assign accept   = complete && ((state_q == IDLE) || xfer);

  // Window accumulation, independent of the converter
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (STB) begin
      if (complete) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Add-3 correction on every BCD nibble that is 5 or more
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 5; i++) begin
      if (sr_q[16+4*i +: 4] >= 4'd5)
        sr_adj[16+4*i +: 4] = sr_q[16+4*i +: 4] + 4'd3;
    end
  end

  // Converter next state, result load and drop detection
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    bcd_d   = bcd_q;
    drop_d  = complete && !accept;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        sr_d  = sr_adj << 1;
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd15) begin
          bcd_d   = sr_d[35:16];
          state_d = DONE;
        end
      end
      DONE: begin
        if (READY)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      sr_d    = {20'b0, avg};
      bit_d   = 4'd0;
      state_d = SHIFT;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      bcd_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      bcd_q   <= bcd_d;
      drop_q  <= drop_d;
    end
  end

  assign BCD_OUT = bcd_q;
  assign VALID   = (state_q == DONE);
  assign BUSY    = (state_q == SHIFT);
  assign DROP    = drop_q;

endmodule
